// File: rtl/partial_sums_scheduler.sv
// partial_sums_scheduler: owns the SC polar partial-sum register S and issues one-hot distribute beats.
// Optional illegal-request checking is enabled by defining PS_SCHED_ERRCHK_EN.
module partial_sums_scheduler #(
  parameter int n = 3,
  parameter int p = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             bit_value,
  output logic             bit_ready,
  output logic [n-1:0]     bit_idx,
  output logic             frame_done,
  input  logic             req_valid,
  input  logic [n-1:0]     req_base,
  input  logic [n:0]       req_len,
  output logic             req_ready,
  output logic [2**n-1:0]  S,
  output logic [2**n-1:0]  distribute_vector,
  output logic             dist_valid,
  input  logic             dist_ready,
  output logic             dist_last,
  output logic             err
);
  localparam int N = 2**n;
  localparam logic [n:0] STEP = (n+1)'(2**p);
  localparam logic [N-1:0] ONE = N'(1);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;
  logic bit_acc, req_acc, beat_acc, illegal;
  logic [N-1:0] mask;
  logic [n:0] beats, remain;
  logic [n-1:0] pos, pos_nxt;
  always_comb begin
    bit_ready = state == IDLE;
    req_ready = state == IDLE && !bit_valid;
    bit_acc = bit_valid && bit_ready;
    req_acc = req_valid && req_ready;
    beat_acc = state == ISSUE && dist_valid && dist_ready;
    beats = (req_len >> p) == '0 ? (n+1)'(1) : req_len >> p;
    pos_nxt = pos + STEP[n-1:0];
    // S[j] takes u_i for every j whose set bits are a subset of i's
    for (int j = 0; j < N; j++) mask[j] = (n'(j) & ~bit_idx) == '0;
`ifdef PS_SCHED_ERRCHK_EN
    illegal = req_len == '0 || (req_len & (req_len - 1'b1)) != '0 || req_len > (n+1)'(N) ||
              (n+2)'(req_base) + (n+2)'(req_len) > (n+2)'(N);
`else
    illegal = 1'b0;
`endif
    state_nxt = frame_start ? IDLE :
                state == IDLE ? (req_acc && !illegal ? ISSUE : IDLE) :
                (beat_acc && dist_last ? IDLE : ISSUE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S <= '0;
      bit_idx <= '0;
      frame_done <= 1'b0;
      distribute_vector <= '0;
      dist_valid <= 1'b0;
      dist_last <= 1'b0;
      pos <= '0;
      remain <= '0;
      err <= 1'b0;
    end else if (frame_start) begin
      S <= '0;
      bit_idx <= '0;
      frame_done <= 1'b0;
      distribute_vector <= '0;
      dist_valid <= 1'b0;
      dist_last <= 1'b0;
      pos <= '0;
      remain <= '0;
    end else begin
      frame_done <= bit_acc && bit_idx == n'(N-1);
      if (bit_acc) begin
        S <= S ^ (bit_value ? mask : '0);
        bit_idx <= bit_idx + 1'b1;
      end
      if (req_acc && illegal) err <= 1'b1;
      if (req_acc && !illegal) begin
        pos <= req_base;
        remain <= beats - 1'b1;
        dist_valid <= 1'b1;
        distribute_vector <= ONE << req_base;
        dist_last <= beats == (n+1)'(1);
      end else if (beat_acc) begin
        if (dist_last) begin
          dist_valid <= 1'b0;
          distribute_vector <= '0;
          dist_last <= 1'b0;
        end else begin
          pos <= pos_nxt;
          remain <= remain - 1'b1;
          distribute_vector <= ONE << pos_nxt;
          dist_last <= remain == (n+1)'(1);
        end
      end
    end
  end
endmodule
